// File: rtl/decimator_mc.sv
// decimator_mc: multi-channel decimator. In pick mode each result is the first sample of a group.
// Sum mode (signed group sum) exists only when DECIMATOR_MC_AVG_EN is defined.
module decimator_mc_lane #(
  parameter int WIDTH = 8,
  parameter int OW    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             first,
  input  logic             sum_mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] smp,
  output logic [OW-1:0]    res
);
  logic [OW-1:0] smp_x, pick_q, pick_nxt, grp;

  assign smp_x    = {{(OW-WIDTH){smp[WIDTH-1]}}, smp};
  assign pick_nxt = first ? smp_x : pick_q;

  always_ff @(posedge clk) begin
    if (rst)                  pick_q <= '0;
    else if (in_valid && first) pick_q <= smp_x;
  end

`ifdef DECIMATOR_MC_AVG_EN
  logic [OW-1:0] acc_q, acc_nxt;

  // The group-opening sample restarts the sum instead of adding to stale state.
  assign acc_nxt = (first ? '0 : acc_q) + smp_x;
  assign grp     = sum_mode ? acc_nxt : pick_nxt;

  always_ff @(posedge clk) begin
    if (rst)           acc_q <= '0;
    else if (in_valid) acc_q <= acc_nxt;
  end
`else
  logic unused_sum;
  assign unused_sum = sum_mode;
  assign grp        = pick_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst)     res <= '0;
    else if (ld) res <= grp;
  end
endmodule

module decimator_mc #(
  parameter int WIDTH    = 8,
  parameter int NUM_CH   = 2,
  parameter int MAX_RATE = 16,
  parameter int DEC_RATE = 4,
  localparam int CW      = $clog2(MAX_RATE+1),
  localparam int OW      = WIDTH + $clog2(MAX_RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [CW-1:0]        rate,
  input  logic                 rate_load,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_CH*OW-1:0] out_data,
  output logic                 ovf
);
  logic [CW-1:0] rate_q, cnt, rate_clip, eff_rate, eff_cnt;
  logic          first, close, ld, sum_mode;
  logic [NUM_CH-1:0][OW-1:0] res;

  assign rate_clip = (rate == '0)             ? CW'(1) :
                     (rate > CW'(MAX_RATE))   ? CW'(MAX_RATE) : rate;

  // A load in the same cycle as a sample makes that sample open a group at the new rate.
  assign eff_rate = rate_load ? rate_clip : rate_q;
  assign eff_cnt  = rate_load ? '0 : cnt;
  assign first    = (eff_cnt == '0);
  assign close    = in_valid && (eff_cnt == eff_rate - CW'(1));
  assign ld       = close && (!out_valid || out_ready);

`ifdef DECIMATOR_MC_AVG_EN
  logic mode_q;
  always_ff @(posedge clk) begin
    if (rst)            mode_q <= 1'b0;
    else if (rate_load) mode_q <= mode;
  end
  assign sum_mode = rate_load ? mode : mode_q;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign sum_mode    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q    <= CW'(DEC_RATE);
      cnt       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (rate_load) rate_q <= rate_clip;
      if (in_valid)       cnt <= close ? '0 : eff_cnt + CW'(1);
      else if (rate_load) cnt <= '0;
      out_valid <= ld | (out_valid & ~out_ready);
      ovf       <= ovf | (close & out_valid & ~out_ready);
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    decimator_mc_lane #(.WIDTH(WIDTH), .OW(OW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .first    (first),
      .sum_mode (sum_mode),
      .ld       (ld),
      .smp      (in_data[c*WIDTH +: WIDTH]),
      .res      (res[c])
    );
  end

  assign out_data = res;
endmodule

// File: doc/decimator_mc.md
DECIMATOR_MC -- requirements
Module: decimator_mc

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 8, bits per channel sample, signed two's complement.
- NUM_CH, 2, number of parallel channels.
- MAX_RATE, 16, largest decimation rate, at least 2.
- DEC_RATE, 4, rate after reset, in 1..MAX_RATE.
REQ-002 Derived widths SHALL be CW = $clog2(MAX_RATE+1) and OW = WIDTH + $clog2(MAX_RATE).
REQ-003 The block SHALL have these ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample strobe for all channels.
- in_data  in  NUM_CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
- rate  in  CW  requested decimation rate.
- rate_load  in  1  load rate (and mode) this cycle.
- mode  in  1  0 = pick, 1 = sum (see REQ-020).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  NUM_CH*OW  channel c in bits [c*OW +: OW].
- ovf  out  1  sticky flag: a result was dropped.

Function
REQ-004 A sample SHALL be accepted on any cycle with in_valid=1.
REQ-005 A phase counter cnt SHALL run 0..rate_q-1 and advance by one per accepted sample.
REQ-006 When cnt = rate_q-1 and a sample is accepted, the group SHALL close and cnt SHALL return to 0.
REQ-007 Pick mode: each channel's result SHALL be its cnt=0 sample of the group, sign-extended to OW.
REQ-008 Results SHALL be registered: out_valid rises on the cycle after the group-closing sample, so latency is 1 cycle.
REQ-009 out_valid and out_data SHALL hold until a cycle with out_valid=1 and out_ready=1.
REQ-010 If a result is due while out_valid=1 and out_ready=0, the new result SHALL be dropped, out_data SHALL be unchanged and ovf SHALL be set.
REQ-011 If a result is due while out_valid=1 and out_ready=1, the new result SHALL be loaded and out_valid SHALL stay 1, with no bubble.
REQ-012 With rate_q = 1, every accepted sample SHALL produce a result.
REQ-013 On rate_load=1, rate_q SHALL become rate, with 0 mapped to 1 and values above MAX_RATE clamped to MAX_RATE.
REQ-014 On rate_load=1, cnt SHALL clear and any partial group SHALL be discarded.
REQ-015 If rate_load and in_valid occur in the same cycle, that sample SHALL be cnt=0 of a new group at the new rate.
REQ-016 rate_load SHALL NOT affect a result already held in the output register.
REQ-017 ovf SHALL clear only on reset.

Reset
REQ-018 When rst=1 at posedge clk, the block SHALL set:
- out_valid=0, out_data=0, ovf=0
- cnt=0, accumulators=0
- rate_q=DEC_RATE, mode_q=0 (pick).
REQ-019 Reset in mid-group SHALL discard the partial group, and the first sample accepted after reset SHALL be cnt=0.

Configuration
REQ-020 Macro DECIMATOR_MC_AVG_EN SHALL control sum mode.
- Defined: mode is sampled into mode_q on rate_load. With mode_q=1, each channel's result is the signed sum of all rate_q samples in the group, in OW bits with no overflow or truncation. mode_q changes only on rate_load or reset.
- Undefined: mode is ignored, mode_q is fixed at 0, and no accumulator logic is synthesised.

Verification
REQ-021 Pick, rate 4, NUM_CH=2, out_ready=1, ch0 samples 1..8 on consecutive cycles -> two results, 1 and 5, each one cycle after samples 4 and 8.
REQ-022 rate_load with rate=0, then 3 samples -> three results (rate 1); rate_load with rate=31 -> rate_q=16.
REQ-023 out_ready=0 while two groups complete -> first result held, second dropped, ovf=1 until rst.
REQ-024 Rate 4, rate_load with rate=2 after 3 samples, simultaneous with sample 9 -> partial group discarded, next result=9 after samples 9,10.
REQ-025 With DECIMATOR_MC_AVG_EN, sum mode, rate 4, ch0 samples 127,127,127,127 and ch1 -128 x4 -> out ch0=508, ch1=-512.
REQ-026 rst asserted after 2 of 4 samples -> outputs 0; after release, samples 7,8,9,10 -> result 7.
